// File: rtl/key_led_pkg.sv
// Shared definitions for the key-driven LED mode controller.
// Holds the mode encodings, LED pattern constants and the LED pattern decode.
package key_led_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 3'd0,
    MODE_FLOW_L = 3'd1,
    MODE_FLOW_R = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_ALL_ON = 3'd4
  } mode_t;

  localparam logic [3:0] LED_OFF = 4'b0000;
  localparam logic [3:0] LED_ALL = 4'b1111;

  // LED pattern for a given mode and pattern step.
  function automatic logic [3:0] led_decode(input mode_t m, input logic [1:0] s);
    logic [3:0] pat;
    pat = LED_OFF;
    case (m)
      MODE_FLOW_L: pat = 4'b0001 << s;
      MODE_FLOW_R: pat = 4'b1000 >> s;
      MODE_BLINK:  pat = s[0] ? LED_OFF : LED_ALL;
      MODE_ALL_ON: pat = LED_ALL;
      default:     pat = LED_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key synchronizer, debouncer and press-event generator.
// Ports:
//   i_clk   - system clock
//   i_rst   - asynchronous reset, active-high
//   i_key   - raw key, active-low, asynchronous to i_clk
//   o_press - one-cycle pulse the cycle after the debounced level falls
// Arming: after reset the debounced level is only an assumption (1). No press
// is reported until the key has been seen stable high for DEB_CYCLES, so a key
// held through reset release must be released and pressed again.
module key_debounce #(
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 25
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync_q;
  logic             r_level;
  logic             r_level_q;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             w_busy;
  logic [CNT_W-1:0] w_cnt_max;

  assign w_cnt_max = CNT_W'(DEB_CYCLES - 1);
  // Until armed, keep qualifying the input even when it equals the level.
  assign w_busy    = (r_sync2 != r_level) | ~r_armed;
  assign o_press   = r_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_sync_q  <= 1'b1;
      r_level   <= 1'b1;
      r_level_q <= 1'b1;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_key;
      r_sync2   <= r_sync1;
      r_sync_q  <= r_sync2;
      r_level_q <= r_level;
      r_press   <= r_level_q & ~r_level & r_armed;
      if (!w_busy) begin
        r_cnt <= '0;
      end else if (!r_armed && (r_sync2 != r_sync_q)) begin
        // Unarmed: any input edge restarts the stability window.
        r_cnt <= '0;
      end else if (r_cnt == w_cnt_max) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        if (r_sync2) r_armed <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_mode_ctrl.sv
// Key-driven LED mode controller (top).
// Four debounced active-low keys select an LED pattern which a mode FSM
// latches; a step timer sequences the pattern and the LEDs are decoded one
// cycle after mode/step.
// Ports:
//   sys_clk   - system clock
//   sys_rst   - asynchronous reset, active-high
//   key[3:0]  - raw push keys, active-low
//   led[3:0]  - registered LED drive, 1 = on
//   mode[2:0] - current mode (FSM state)
//   step[1:0] - current pattern step
//   step_tick - one-cycle pulse on each step advance
//   press_evt - per-key one-cycle press pulses
// Optional feature macro: KEY_MODE_AUTO_OFF_EN adds IDLE_STEPS; after that many
// step ticks with no press and no mode change the mode returns to IDLE.
module key_mode_ctrl
  import key_led_pkg::*;
#(
  parameter int DEB_CYCLES  = 1000000,
  parameter int STEP_CYCLES = 25000000,
  parameter int CNT_W       = 25
`ifdef KEY_MODE_AUTO_OFF_EN
  ,
  parameter int IDLE_STEPS  = 120
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [3:0]        key,
  output logic [3:0]        led,
  output logic [MODE_W-1:0] mode,
  output logic [1:0]        step,
  output logic              step_tick,
  output logic [3:0]        press_evt
);

  logic [3:0]       w_press;
  mode_t            r_mode;
  mode_t            w_mode_nxt;
  mode_t            w_target;
  logic             w_mode_chg;
  logic [CNT_W-1:0] r_step_cnt;
  logic [1:0]       r_step;
  logic             r_tick;
  logic [3:0]       r_led;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .i_clk  (sys_clk),
      .i_rst  (sys_rst),
      .i_key  (key[g]),
      .o_press(w_press[g])
    );
  end

`ifdef KEY_MODE_AUTO_OFF_EN
  localparam int IW = $clog2(IDLE_STEPS + 1);
  logic [IW-1:0] r_idle_cnt;
`endif

  // Mode FSM: state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_mode <= MODE_IDLE;
    else         r_mode <= w_mode_nxt;
  end

  // Mode FSM: next state. Lowest-numbered key wins; the others are dropped.
  always_comb begin
    w_target   = MODE_IDLE;
    w_mode_nxt = r_mode;
    if      (w_press[0]) w_target = MODE_FLOW_L;
    else if (w_press[1]) w_target = MODE_FLOW_R;
    else if (w_press[2]) w_target = MODE_BLINK;
    else if (w_press[3]) w_target = MODE_ALL_ON;
    if (|w_press) begin
      w_mode_nxt = (w_target == r_mode) ? MODE_IDLE : w_target;
    end
`ifdef KEY_MODE_AUTO_OFF_EN
    else if ((r_mode != MODE_IDLE) && (r_idle_cnt == IW'(IDLE_STEPS))) begin
      w_mode_nxt = MODE_IDLE;
    end
`endif
  end

  assign w_mode_chg = (w_mode_nxt != r_mode);

  // Step timer. A mode change restarts the pattern at step 0; IDLE holds it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_step_cnt <= '0;
      r_step     <= 2'd0;
      r_tick     <= 1'b0;
    end else if (w_mode_chg || (r_mode == MODE_IDLE)) begin
      r_step_cnt <= '0;
      r_step     <= 2'd0;
      r_tick     <= 1'b0;
    end else if (r_step_cnt == CNT_W'(STEP_CYCLES - 1)) begin
      r_step_cnt <= '0;
      r_step     <= r_step + 2'd1;
      r_tick     <= 1'b1;
    end else begin
      r_step_cnt <= r_step_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

`ifdef KEY_MODE_AUTO_OFF_EN
  // Step ticks since the last press or mode change; saturates at IDLE_STEPS.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_idle_cnt <= '0;
    end else if ((|w_press) || w_mode_chg) begin
      r_idle_cnt <= '0;
    end else if (r_tick && (r_idle_cnt != IW'(IDLE_STEPS))) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_led <= LED_OFF;
    else         r_led <= led_decode(r_mode, r_step);
  end

  assign led       = r_led;
  assign mode      = r_mode;
  assign step      = r_step;
  assign step_tick = r_tick;
  assign press_evt = w_press;

endmodule
